// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: architectural source indices and
// small index helpers.
package wb_arbiter_pkg;

  localparam int WB_WORD_WIDTH = 32;
  localparam int WB_ROB_DEPTH  = 16;

  localparam int WB_NUM_SRC   = 5;
  localparam int WB_SRC_IDX_W = 3;

  localparam logic [WB_SRC_IDX_W-1:0] WB_SRC_ALU  = 3'd0;
  localparam logic [WB_SRC_IDX_W-1:0] WB_SRC_MUL  = 3'd1;
  localparam logic [WB_SRC_IDX_W-1:0] WB_SRC_DIV  = 3'd2;
  localparam logic [WB_SRC_IDX_W-1:0] WB_SRC_LOAD = 3'd3;
  localparam logic [WB_SRC_IDX_W-1:0] WB_SRC_BR   = 3'd4;

  // Successor of a source index in the circular scan order (4 wraps to 0).
  function automatic logic [WB_SRC_IDX_W-1:0] wb_next_idx(input logic [WB_SRC_IDX_W-1:0] idx);
    return (idx >= WB_SRC_BR) ? WB_SRC_ALU : idx + 3'd1;
  endfunction

  function automatic int wb_count(input logic [WB_NUM_SRC-1:0] mask);
    int n;
    n = 0;
    for (int i = 0; i < WB_NUM_SRC; i++) begin
      n = n + int'(mask[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after start,
// scanning upward modulo WB_NUM_SRC. Returns one-hot grant, index and a found flag.
module wb_arbiter_rr_pick
  import wb_arbiter_pkg::*;
(
  input  logic [WB_NUM_SRC-1:0]   req,
  input  logic [WB_SRC_IDX_W-1:0] start,
  output logic [WB_NUM_SRC-1:0]   gnt,
  output logic [WB_SRC_IDX_W-1:0] idx,
  output logic                    found
);

  logic [WB_SRC_IDX_W-1:0] pos;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = start;
    for (int k = 0; k < WB_NUM_SRC; k++) begin
      if (!found && req[pos]) begin
        found    = 1'b1;
        idx      = pos;
        gnt[pos] = 1'b1;
      end
      pos = wb_next_idx(pos);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: five one-entry result buffers broadcast round-robin onto
// NUM_PORTS common-data-bus ports. Optional macro WB_ARB_PERF_EN adds wb_conflict_cnt.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WORD_WIDTH = WB_WORD_WIDTH,
  parameter int ROB_DEPTH  = WB_ROB_DEPTH,
  parameter int NUM_SRC    = WB_NUM_SRC,
  parameter int NUM_PORTS  = 2,
  localparam int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic [NUM_SRC-1:0]                 src_valid,
  input  logic [NUM_SRC*WORD_WIDTH-1:0]      src_data,
  input  logic [NUM_SRC*TAG_W-1:0]           src_tag,
  output logic [NUM_SRC-1:0]                 src_ready,
  output logic [NUM_PORTS-1:0]               wb_valid,
  output logic [NUM_PORTS*WORD_WIDTH-1:0]    wb_data,
  output logic [NUM_PORTS*TAG_W-1:0]         wb_tag,
  output logic [NUM_PORTS*WB_SRC_IDX_W-1:0]  wb_src
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]                        wb_conflict_cnt
`endif
);

  // Handshake: a result transfers into buffer i at a clk edge where
  // src_valid[i] && src_ready[i] && !flush; the source must hold it until then.
  // src_ready[i] is high when the buffer is empty or being broadcast this cycle,
  // so a continuously granted source sustains one result per cycle.

  logic [NUM_SRC-1:0]      buf_valid;
  logic [WORD_WIDTH-1:0]   buf_data [NUM_SRC];
  logic [TAG_W-1:0]        buf_tag  [NUM_SRC];
  logic [WB_SRC_IDX_W-1:0] rr_ptr;

  logic                    active;
  logic [NUM_SRC-1:0]      req;
  logic [NUM_SRC-1:0]      granted;
  logic [WB_SRC_IDX_W-1:0] last_idx;

  logic [NUM_PORTS-1:0]    pfound;
  logic [WB_SRC_IDX_W-1:0] pidx   [NUM_PORTS];
  logic [WB_SRC_IDX_W-1:0] pstart [NUM_PORTS];
  logic [NUM_SRC-1:0]      preq   [NUM_PORTS];
  logic [NUM_SRC-1:0]      pgnt   [NUM_PORTS];

  // Reset and flush both silence the bus and the ready lines for the cycle.
  assign active = rst_n && !flush;
  assign req    = active ? buf_valid : '0;

  // Each later port scans the leftover requests starting just past the previous winner.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    if (p == 0) begin : g_first
      assign preq[p]   = req;
      assign pstart[p] = rr_ptr;
    end else begin : g_next
      assign preq[p]   = preq[p-1] & ~pgnt[p-1];
      assign pstart[p] = wb_next_idx(pidx[p-1]);
    end

    wb_arbiter_rr_pick u_pick (
      .req   (preq[p]),
      .start (pstart[p]),
      .gnt   (pgnt[p]),
      .idx   (pidx[p]),
      .found (pfound[p])
    );

    assign wb_valid[p] = pfound[p];
    assign wb_data[p*WORD_WIDTH +: WORD_WIDTH]     = pfound[p] ? buf_data[pidx[p]] : '0;
    assign wb_tag[p*TAG_W +: TAG_W]                = pfound[p] ? buf_tag[pidx[p]]  : '0;
    assign wb_src[p*WB_SRC_IDX_W +: WB_SRC_IDX_W]  = pfound[p] ? pidx[p]           : '0;
  end

  always_comb begin
    granted  = '0;
    last_idx = rr_ptr;
    for (int p = 0; p < NUM_PORTS; p++) begin
      granted = granted | pgnt[p];
      if (pfound[p]) begin
        last_idx = pidx[p];
      end
    end
  end

  assign src_ready = active ? (~buf_valid | granted) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid <= '0;
      rr_ptr    <= WB_SRC_ALU;
      for (int i = 0; i < NUM_SRC; i++) begin
        buf_data[i] <= '0;
        buf_tag[i]  <= '0;
      end
    end else if (flush) begin
      buf_valid <= '0;
    end else begin
      // Port 0 is always the first to find a request, so it signals any grant.
      if (pfound[0]) begin
        rr_ptr <= wb_next_idx(last_idx);
      end
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_valid[i] && src_ready[i]) begin
          buf_valid[i] <= 1'b1;
          buf_data[i]  <= src_data[i*WORD_WIDTH +: WORD_WIDTH];
          buf_tag[i]   <= src_tag[i*TAG_W +: TAG_W];
        end else if (granted[i]) begin
          buf_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef WB_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_conflict_cnt <= '0;
    end else if (!flush && (wb_count(buf_valid) > NUM_PORTS) && (wb_conflict_cnt != '1)) begin
      wb_conflict_cnt <= wb_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, hand sequences for single result
// and reset mid-operation, then randomized traffic against a queue-based model.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int W      = 32;
  localparam int TW     = 4;
  localparam int NP     = 2;
  localparam int NS     = 5;
  localparam int PW     = 3 + TW + W;
  localparam int EW     = NS + NP + NP*PW;
  localparam int N_RAND = 600;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic [NS-1:0]   src_valid = '0;
  logic [NS*W-1:0] src_data = '0;
  logic [NS*TW-1:0] src_tag = '0;
  logic [NS-1:0]   src_ready;
  logic [NP-1:0]   wb_valid;
  logic [NP*W-1:0] wb_data;
  logic [NP*TW-1:0] wb_tag;
  logic [NP*3-1:0] wb_src;
`ifdef WB_ARB_PERF_EN
  logic [31:0]     wb_conflict_cnt;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  wb_arbiter #(.WORD_WIDTH(W), .ROB_DEPTH(16), .NUM_SRC(NS), .NUM_PORTS(NP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_tag   (src_tag),
    .src_ready (src_ready),
    .wb_valid  (wb_valid),
    .wb_data   (wb_data),
    .wb_tag    (wb_tag),
    .wb_src    (wb_src)
`ifdef WB_ARB_PERF_EN
    ,
    .wb_conflict_cnt (wb_conflict_cnt)
`endif
  );

  // clock/reset block
  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          f;
    logic [NS-1:0] v;
    logic [NS*TW-1:0] t;
    logic [NS-1:0] rdy;
    logic [NP-1:0] wv;
    logic [2:0]    s0;
    logic [TW-1:0] t0;
    logic [2:0]    s1;
    logic [TW-1:0] t1;
  } vec_t;

  vec_t tbl[$];
  logic [EW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] mk_data(input int s, input logic [TW-1:0] t);
    return {16'hC0DE, 4'(s), 4'h0, 4'h0, t};
  endfunction

  function automatic logic [PW-1:0] port_act(input int p);
    return {wb_src[p*3 +: 3], wb_tag[p*TW +: TW], wb_data[p*W +: W]};
  endfunction

  // driver tasks
  task automatic drive(input logic r, input logic f, input logic [NS-1:0] v, input logic [NS*TW-1:0] t);
    rst_n = r;
    flush = f;
    src_valid = v;
    src_tag = t;
    for (int i = 0; i < NS; i++) src_data[i*W +: W] = mk_data(i, t[i*TW +: TW]);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic f, input logic [NS-1:0] v, input logic [NS*TW-1:0] t,
                     input logic [NS-1:0] rdy, input logic [NP-1:0] wv,
                     input logic [2:0] s0, input logic [TW-1:0] t0,
                     input logic [2:0] s1, input logic [TW-1:0] t1);
    vec_t e;
    e.r = r; e.f = f; e.v = v; e.t = t; e.rdy = rdy; e.wv = wv;
    e.s0 = s0; e.t0 = t0; e.s1 = s1; e.t1 = t1;
    tbl.push_back(e);
  endtask

  // behavioural model state
  bit            m_valid [NS];
  logic [W-1:0]  m_data  [NS];
  logic [TW-1:0] m_tag   [NS];
  int            m_ptr;
  logic [31:0]   m_cnt;

  initial begin
    logic r, f;
    logic [NS-1:0] v, gr, rdy;
    logic [NP-1:0] e_wv;
    logic [PW-1:0] e_port [NP];
    logic [EW-1:0] e;
    int order[$];
    int nv, j;

    // ---------------- directed vector table ----------------
    //   r  f  valid     tags        ready     wv     s0 t0  s1 t1
    add(0, 0, 5'b00000, 20'h00000, 5'b00000, 2'b00, 0, 0, 0, 0);
    add(0, 0, 5'b11111, 20'h54321, 5'b00000, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b00, 0, 0, 0, 0);
    // full contention from pointer 0
    add(1, 0, 5'b11111, 20'h54321, 5'b11111, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b00011, 2'b11, 0, 1, 1, 2);
    add(1, 0, 5'b00000, 20'h00000, 5'b01111, 2'b11, 2, 3, 3, 4);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b01, 4, 5, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b00, 0, 0, 0, 0);
    // move pointer to 4, then wrap-around grant 4 then 0
    add(1, 0, 5'b01000, 20'h07000, 5'b11111, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b10001, 20'h90008, 5'b11111, 2'b01, 3, 7, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b11, 4, 9, 0, 8);
    // pointer is now 1: source 1 must win over source 0
    add(1, 0, 5'b00011, 20'h00032, 5'b11111, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b11, 1, 3, 0, 2);
    // back-to-back mul results
    add(1, 0, 5'b00010, 20'h00040, 5'b11111, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b00010, 20'h00050, 5'b11111, 2'b01, 1, 4, 0, 0);
    add(1, 0, 5'b00010, 20'h00060, 5'b11111, 2'b01, 1, 5, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b01, 1, 6, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b00, 0, 0, 0, 0);
    // flush with buffers 1 and 3 held and a load arriving
    add(1, 0, 5'b01010, 20'h02010, 5'b11111, 2'b00, 0, 0, 0, 0);
    add(1, 1, 5'b01000, 20'h0F000, 5'b00000, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b00, 0, 0, 0, 0);
    // pointer held at 2 across the flush
    add(1, 0, 5'b00101, 20'h00201, 5'b11111, 2'b00, 0, 0, 0, 0);
    add(1, 0, 5'b00000, 20'h00000, 5'b11111, 2'b11, 2, 2, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].t);
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 64'(src_ready), 64'(tbl[i].rdy));
      chk($sformatf("row%0d wb_valid", i), 64'(wb_valid), 64'(tbl[i].wv));
      chk($sformatf("row%0d port0", i), 64'(port_act(0)),
          tbl[i].wv[0] ? 64'({tbl[i].s0, tbl[i].t0, mk_data(int'(tbl[i].s0), tbl[i].t0)}) : 64'd0);
      chk($sformatf("row%0d port1", i), 64'(port_act(1)),
          tbl[i].wv[1] ? 64'({tbl[i].s1, tbl[i].t1, mk_data(int'(tbl[i].s1), tbl[i].t1)}) : 64'd0);
      next_cycle();
    end

    // ---------------- single alu result ----------------
    drive(0, 0, '0, '0);
    next_cycle();
    drive(1, 0, 5'b00001, 20'h00003);
    src_data[W-1:0] = 32'h12345678;
    @(negedge clk);
    chk("single ready", 64'(src_ready), 64'h1F);
    next_cycle();
    drive(1, 0, '0, '0);
    @(negedge clk);
    chk("single wb_valid", 64'(wb_valid), 64'h1);
    chk("single data", 64'(wb_data[W-1:0]), 64'h12345678);
    chk("single tag", 64'(wb_tag[TW-1:0]), 64'h3);
    chk("single src", 64'(wb_src[2:0]), 64'(WB_SRC_ALU));
    next_cycle();
    @(negedge clk);
    chk("single idle", 64'(wb_valid), 64'h0);

    // ---------------- reset mid-operation (pointer is 1 here) ----------------
    drive(1, 0, 5'b11111, 20'h54321);
    next_cycle();
    drive(1, 0, '0, '0);
    @(negedge clk);
    chk("midrst grant", 64'({wb_valid, wb_src}), 64'({2'b11, 3'd2, 3'd1}));
    chk("midrst ready", 64'(src_ready), 64'b00110);
    next_cycle();
    drive(0, 0, '0, '0);
    @(negedge clk);
    chk("midrst in-reset ready", 64'(src_ready), 64'h0);
    chk("midrst in-reset wb_valid", 64'(wb_valid), 64'h0);
`ifdef WB_ARB_PERF_EN
    chk("midrst cnt before", 64'(wb_conflict_cnt), 64'd1);
`endif
    next_cycle();
    drive(1, 0, '0, '0);
    @(negedge clk);
    chk("midrst release wb_valid", 64'(wb_valid), 64'h0);
    chk("midrst release ready", 64'(src_ready), 64'h1F);
`ifdef WB_ARB_PERF_EN
    chk("midrst cnt after", 64'(wb_conflict_cnt), 64'd0);
`endif
    next_cycle();
    drive(1, 0, 5'b10001, 20'h20001);
    next_cycle();
    drive(1, 0, '0, '0);
    @(negedge clk);
    chk("midrst ptr0 order", 64'({wb_valid, wb_src}), 64'({2'b11, 3'd4, 3'd0}));
    next_cycle();

    // ---------------- randomized traffic vs. model ----------------
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_data[i] = '0;
      m_tag[i] = '0;
    end
    m_ptr = 0;
    m_cnt = '0;
    for (int k = 0; k < N_RAND; k++) begin
      r = (k < 2) ? 1'b0 : ($urandom_range(0, 47) != 0);
      f = ($urandom_range(0, 11) == 0);
      v = NS'($urandom_range(0, 31));
      rst_n = r;
      flush = f;
      src_valid = v;
      for (int i = 0; i < NS; i++) begin
        src_data[i*W +: W] = $urandom();
        src_tag[i*TW +: TW] = TW'($urandom_range(0, 15));
      end

      // Valid buffers listed in scan order from the pointer; the first NP win.
      order.delete();
      gr = '0;
      e_wv = '0;
      for (int p = 0; p < NP; p++) e_port[p] = '0;
      if (r && !f) begin
        for (int s = 0; s < NS; s++) begin
          j = (m_ptr + s) % NS;
          if (m_valid[j]) order.push_back(j);
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (p < order.size()) begin
          j = order[p];
          gr[j] = 1'b1;
          e_wv[p] = 1'b1;
          e_port[p] = {3'(j), m_tag[j], m_data[j]};
        end
      end
      for (int i = 0; i < NS; i++) rdy[i] = r && !f && (!m_valid[i] || gr[i]);
      exp_q.push_back({rdy, e_wv, e_port[1], e_port[0]});

      // scoreboard
      @(negedge clk);
      e = exp_q.pop_front();
      chk($sformatf("rand%0d ready", k), 64'(src_ready), 64'(e[EW-1 -: NS]));
      chk($sformatf("rand%0d wb_valid", k), 64'(wb_valid), 64'(e[2*PW +: NP]));
      chk($sformatf("rand%0d port0", k), 64'(port_act(0)), 64'(e[0 +: PW]));
      chk($sformatf("rand%0d port1", k), 64'(port_act(1)), 64'(e[PW +: PW]));
`ifdef WB_ARB_PERF_EN
      chk($sformatf("rand%0d conflict_cnt", k), 64'(wb_conflict_cnt), 64'(m_cnt));
`endif
      @(posedge clk);

      nv = 0;
      for (int i = 0; i < NS; i++) nv += int'(m_valid[i]);
      if (!r) begin
        for (int i = 0; i < NS; i++) begin
          m_valid[i] = 1'b0;
          m_data[i] = '0;
          m_tag[i] = '0;
        end
        m_ptr = 0;
        m_cnt = '0;
      end else if (f) begin
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
      end else begin
        if (nv > NP && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (order.size() > 0) begin
          j = (order.size() < NP) ? order[order.size()-1] : order[NP-1];
          m_ptr = (j + 1) % NS;
        end
        for (int i = 0; i < NS; i++) begin
          if (gr[i]) m_valid[i] = 1'b0;
          if (v[i] && rdy[i]) begin
            m_valid[i] = 1'b1;
            m_data[i] = src_data[i*W +: W];
            m_tag[i] = src_tag[i*TW +: TW];
          end
        end
      end
      #1;
    end

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
